// File: rtl/physics_pkg.sv
// Shared types and width defaults for the soft-body physics datapath.
package physics_pkg;

  localparam int unsigned PositionSizeDefault = 8;
  localparam int unsigned VelocitySizeDefault = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWait,
    StNext,
    StWrite,
    StDone
  } sched_state_e;

  typedef struct packed {
    logic signed [PositionSizeDefault-1:0] x;
    logic signed [PositionSizeDefault-1:0] y;
    logic signed [VelocitySizeDefault-1:0] vx;
    logic signed [VelocitySizeDefault-1:0] vy;
  } node_state_t;

endpackage

// File: rtl/collision_scheduler.sv
// Walks every node against the active obstacle list once per frame, driving the shared
// collision engine and writing each node's resolved position back to node memory.
module collision_scheduler
  import physics_pkg::*;
#(
  parameter int unsigned NUM_NODES     = 8,
  parameter int unsigned NUM_OBSTACLES = 4,
  parameter int unsigned POSITION_SIZE = PositionSizeDefault,
  parameter int unsigned VELOCITY_SIZE = VelocitySizeDefault,
  parameter int          DT            = 1,
  parameter int unsigned TIMEOUT       = 255,
  localparam int unsigned NW = $clog2(NUM_NODES),
  localparam int unsigned OW = $clog2(NUM_OBSTACLES),
  localparam int unsigned CW = $clog2(NUM_OBSTACLES) + 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  input  logic [CW-1:0]            num_obstacles_in,
  output logic                     busy_out,
  output logic                     done_out,
  output logic                     error_out,
  output logic [NW-1:0]            node_idx_out,
  input  logic [POSITION_SIZE-1:0] node_x_in,
  input  logic [POSITION_SIZE-1:0] node_y_in,
  input  logic [VELOCITY_SIZE-1:0] node_vx_in,
  input  logic [VELOCITY_SIZE-1:0] node_vy_in,
  output logic [OW-1:0]            obs_idx_out,
  output logic                     eng_begin_out,
  output logic [POSITION_SIZE-1:0] eng_x_out,
  output logic [POSITION_SIZE-1:0] eng_y_out,
  output logic [VELOCITY_SIZE-1:0] eng_vx_out,
  output logic [VELOCITY_SIZE-1:0] eng_vy_out,
  input  logic                     eng_result_in,
  input  logic                     eng_collision_in,
  input  logic [POSITION_SIZE-1:0] eng_x_in,
  input  logic [POSITION_SIZE-1:0] eng_y_in,
  output logic                     wr_valid_out,
  output logic [NW-1:0]            wr_idx_out,
  output logic [POSITION_SIZE-1:0] wr_x_out,
  output logic [POSITION_SIZE-1:0] wr_y_out,
  output logic                     wr_collided_out
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  sched_state_e           state_q, state_d;
  logic [NW-1:0]          node_idx_q, node_idx_d;
  logic [OW-1:0]          obs_idx_q, obs_idx_d;
  logic [CW-1:0]          count_q, count_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [POSITION_SIZE-1:0] res_x_q, res_x_d, res_y_q, res_y_d;
  logic                   res_coll_q, res_coll_d;
  logic                   use_ff_q, use_ff_d;
  logic                   busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic                   eng_begin_q, eng_begin_d;
  logic [POSITION_SIZE-1:0] eng_x_q, eng_x_d, eng_y_q, eng_y_d;
  logic [VELOCITY_SIZE-1:0] eng_vx_q, eng_vx_d, eng_vy_q, eng_vy_d;
  logic                   wr_valid_q, wr_valid_d, wr_coll_q, wr_coll_d;
  logic [NW-1:0]          wr_idx_q, wr_idx_d;
  logic [POSITION_SIZE-1:0] wr_x_q, wr_x_d, wr_y_q, wr_y_d;
  logic [POSITION_SIZE-1:0] ff_x, ff_y;

  always_comb begin
    state_d     = state_q;
    node_idx_d  = node_idx_q;
    obs_idx_d   = obs_idx_q;
    count_d     = count_q;
    tmo_d       = tmo_q;
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    res_coll_d  = res_coll_q;
    use_ff_d    = use_ff_q;
    done_d      = 1'b0;
    error_d     = error_q;
    eng_begin_d = 1'b0;
    eng_x_d     = eng_x_q;
    eng_y_d     = eng_y_q;
    eng_vx_d    = eng_vx_q;
    eng_vy_d    = eng_vy_q;
    wr_valid_d  = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_x_d      = wr_x_q;
    wr_y_d      = wr_y_q;
    wr_coll_d   = wr_coll_q;
    // Node data is valid from the cycle after LOAD, so free flight is resolved in WRITE.
    ff_x = POSITION_SIZE'(32'(signed'(node_x_in)) + 32'(signed'(node_vx_in)) * DT);
    ff_y = POSITION_SIZE'(32'(signed'(node_y_in)) + 32'(signed'(node_vy_in)) * DT);

    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          state_d    = StLoad;
          node_idx_d = '0;
          obs_idx_d  = '0;
          error_d    = 1'b0;
          count_d    = (num_obstacles_in > CW'(NUM_OBSTACLES)) ? CW'(NUM_OBSTACLES)
                                                                : num_obstacles_in;
        end
      end
      StLoad: begin
        res_coll_d = 1'b0;
        use_ff_d   = (count_q == '0);
        state_d    = (count_q == '0) ? StWrite : StIssue;
      end
      StIssue: begin
        eng_x_d     = node_x_in;
        eng_y_d     = node_y_in;
        eng_vx_d    = node_vx_in;
        eng_vy_d    = node_vy_in;
        eng_begin_d = 1'b1;
        tmo_d       = '0;
        state_d     = StWait;
      end
      StWait: begin
        if (eng_result_in) begin
          res_x_d    = eng_x_in;
          res_y_d    = eng_y_in;
          res_coll_d = eng_collision_in;
          state_d    = StNext;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          error_d  = 1'b1;
          use_ff_d = 1'b1;
          state_d  = StWrite;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StNext: begin
        if (res_coll_q || (({1'b0, obs_idx_q} + CW'(1)) == count_q)) begin
          state_d = StWrite;
        end else begin
          obs_idx_d = obs_idx_q + 1'b1;
          state_d   = StIssue;
        end
      end
      StWrite: begin
        wr_valid_d = 1'b1;
        wr_idx_d   = node_idx_q;
        wr_x_d     = use_ff_q ? ff_x : res_x_q;
        wr_y_d     = use_ff_q ? ff_y : res_y_q;
        wr_coll_d  = !use_ff_q && res_coll_q;
        if (node_idx_q == NW'(NUM_NODES - 1)) begin
          state_d = StDone;
        end else begin
          node_idx_d = node_idx_q + 1'b1;
          obs_idx_d  = '0;
          state_d    = StLoad;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      node_idx_q  <= '0;
      obs_idx_q   <= '0;
      count_q     <= '0;
      tmo_q       <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_coll_q  <= 1'b0;
      use_ff_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      eng_begin_q <= 1'b0;
      eng_x_q     <= '0;
      eng_y_q     <= '0;
      eng_vx_q    <= '0;
      eng_vy_q    <= '0;
      wr_valid_q  <= 1'b0;
      wr_idx_q    <= '0;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      wr_coll_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      node_idx_q  <= node_idx_d;
      obs_idx_q   <= obs_idx_d;
      count_q     <= count_d;
      tmo_q       <= tmo_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      res_coll_q  <= res_coll_d;
      use_ff_q    <= use_ff_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      eng_begin_q <= eng_begin_d;
      eng_x_q     <= eng_x_d;
      eng_y_q     <= eng_y_d;
      eng_vx_q    <= eng_vx_d;
      eng_vy_q    <= eng_vy_d;
      wr_valid_q  <= wr_valid_d;
      wr_idx_q    <= wr_idx_d;
      wr_x_q      <= wr_x_d;
      wr_y_q      <= wr_y_d;
      wr_coll_q   <= wr_coll_d;
    end
  end

  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign error_out       = error_q;
  assign node_idx_out    = node_idx_q;
  assign obs_idx_out     = obs_idx_q;
  assign eng_begin_out   = eng_begin_q;
  assign eng_x_out       = eng_x_q;
  assign eng_y_out       = eng_y_q;
  assign eng_vx_out      = eng_vx_q;
  assign eng_vy_out      = eng_vy_q;
  assign wr_valid_out    = wr_valid_q;
  assign wr_idx_out      = wr_idx_q;
  assign wr_x_out        = wr_x_q;
  assign wr_y_out        = wr_y_q;
  assign wr_collided_out = wr_coll_q;

endmodule

// File: doc/collision_scheduler.md
# collision_scheduler

Sequences the single shared `do_collision` engine over every node of the soft-body car and every obstacle in the level, once per physics frame. For each node it walks the obstacle list, issuing one engine request per obstacle. It stops at the first obstacle that reports a collision, or takes the free-flight result after the last obstacle. It then writes the node's new position back to the node state memory. It sits between the frame timer/physics top level and the collision engine, and owns the engine's begin/result handshake.

## Interface
Parameters:
- `NUM_NODES`, 8: car nodes per frame.
- `NUM_OBSTACLES`, 4: maximum obstacles; the obstacle index is `$clog2(NUM_OBSTACLES)` bits wide.
- `POSITION_SIZE`, 8: width of positions, signed.
- `VELOCITY_SIZE`, 8: width of velocities, signed.
- `DT`, 1: timestep used by the local free-flight path.
- `TIMEOUT`, 255: maximum number of WAIT cycles before the request is aborted.

Ports (one clock; reset is synchronous and active-high):
- `clk_in` in, 1: clock.
- `rst_in` in, 1: synchronous active-high reset.
- `start_in` in, 1: frame start pulse.
- `num_obstacles_in` in, `$clog2(NUM_OBSTACLES)+1`: active obstacle count; sampled at start.
- `busy_out` out, 1: high in every state except IDLE.
- `done_out` out, 1: one-cycle pulse at end of frame.
- `error_out` out, 1: sticky engine-timeout flag; cleared by reset or by an accepted `start_in`.
- `node_idx_out` out, `$clog2(NUM_NODES)`: node memory read address.
- `node_x_in`, `node_y_in` in, `POSITION_SIZE`: node position; valid 1 cycle after the address.
- `node_vx_in`, `node_vy_in` in, `VELOCITY_SIZE`: node velocity; same timing.
- `obs_idx_out` out, `$clog2(NUM_OBSTACLES)`: obstacle ROM/mux select. The ROM is registered and its data reaches the engine 1 cycle later.
- `eng_begin_out` out, 1: drives the engine's `begin_in`.
- `eng_x_out`, `eng_y_out` out, `POSITION_SIZE`: drive the engine's `pos_x_in`/`pos_y_in`.
- `eng_vx_out`, `eng_vy_out` out, `VELOCITY_SIZE`: drive the engine's `vel_x_in`/`vel_y_in`.
- `eng_result_in` in, 1: engine `result_out`.
- `eng_collision_in` in, 1: engine `was_collision`.
- `eng_x_in`, `eng_y_in` in, `POSITION_SIZE`: engine `x_new`/`y_new`.
- `wr_valid_out` out, 1: one-cycle write strobe.
- `wr_idx_out` out, `$clog2(NUM_NODES)`: write address.
- `wr_x_out`, `wr_y_out` out, `POSITION_SIZE`: written position.
- `wr_collided_out` out, 1: high if the written position came from a collision.

## Operation
State machine: IDLE, LOAD, ISSUE, WAIT, NEXT, WRITE, DONE.
- **Reset:** state goes to IDLE. Every output and every counter is 0, including `error_out`.
- **IDLE:**
  - `start_in` → LOAD, with node_idx=0, obs_idx=0 and `num_obstacles_in` latched.
  - `start_in` in any other state is ignored.
- **LOAD:**
  - Drives `node_idx_out` and `obs_idx_out`.
  - → ISSUE, or → WRITE with the free-flight result if the latched count is 0.
- **ISSUE:**
  - Registers the node data onto the `eng_*_out` ports.
  - Pulses `eng_begin_out` for exactly 1 cycle.
  - Clears the timeout counter and goes → WAIT.
- **WAIT:** holds the `eng_*_out` ports stable.
  - `eng_result_in` → latch `eng_x_in`, `eng_y_in` and `eng_collision_in`, then → NEXT.
  - Timeout counter reaching `TIMEOUT` → set `error_out`, take the free-flight result, mark not collided, → WRITE.
- **NEXT:**
  - Collision latched, or obs_idx == count-1 → WRITE.
  - Otherwise obs_idx++ and → ISSUE. The ROM data is ready by ISSUE.
- **WRITE:**
  - Pulses `wr_valid_out` with `wr_idx_out`=node_idx.
  - If node_idx == NUM_NODES-1 → DONE.
  - Otherwise node_idx++, obs_idx=0, → LOAD.
- **DONE:** pulses `done_out` and goes → IDLE.

Arithmetic:
- Local free-flight result is pos + vel*DT, truncated to `POSITION_SIZE` with two's-complement wrap.
- A non-collision engine result for the last obstacle is written as returned.
- A num_obstacles count larger than `NUM_OBSTACLES` is clamped to `NUM_OBSTACLES`.

## Timing
- Per engine request: ISSUE 1 cycle + engine latency L (cycles from begin to result pulse) + NEXT 1 cycle.
- Per node: LOAD 1 cycle + Σ(requests) + WRITE 1 cycle.
- `done_out` rises 1 cycle after the last `wr_valid_out`.
- `eng_begin_out` is never high while an engine request is outstanding.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- `rst_in` mid-frame returns to IDLE on the next edge, with no write and no done. The engine shares `rst_in`.

## Structure
- Shared package `physics_pkg`: the scheduler state enum, a `node_state_t` struct (x, y, vx, vy), and the `POSITION_SIZE`/`VELOCITY_SIZE` defaults.
- No sub-module. The timeout counter and free-flight adder stay inline.

## Test plan
Bench substitutes a behavioral engine model with programmable latency L and a per-(node, obstacle) response table.
- **Single collision:** NUM_NODES=2, count=2, L=6. Node0 (5,15) vel (10,0) collides on obs0 and returns (8,15). → One engine request for node0; write idx0 (8,15) collided=1. Node1 makes 2 requests, and its write comes from the obs1 result with collided=0.
- **Zero obstacles:** count=0, node (127,0) vel (1,-1). → Write (-128,-1), wrap applied. No `eng_begin_out`. `done_out` 1 cycle after the final write.
- **Timeout:** TIMEOUT=20, engine never responds. → `error_out`=1 after 20 WAIT cycles; free-flight written; frame completes.
  - A following `start_in` clears `error_out`.
- **Start while busy:** `start_in` pulsed in WAIT. → Ignored; exactly NUM_NODES writes and one `done_out`.
- **Reset mid-frame:** `rst_in` asserted during node1's WAIT. → Next cycle all outputs are 0 and state is IDLE. A new start then produces a full frame.
- **Handshake checks:**
  - `eng_begin_out` width is always exactly 1 cycle.
  - `eng_*_out` ports are stable throughout WAIT.
  - Obstacle order is 0..count-1.
